lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit between the single-cycle datapath and a handshaked, variable-latency data memory.
- Replaces direct array access with a request/grant/response initiator.
- Decodes byte, halfword and word loads and stores; generates byte enables; aligns and extends load data.
- Stalls the datapath until the access completes and produces the register writeback value, including the nextPC selection for JAL/JALR.

Parameters:
- DMEM_SIZE, 1024: data memory depth in 32-bit words (power of two).
- ADDR_W, 10: word-address width, equal to log2(DMEM_SIZE).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- Valid  input  1  the datapath presents a valid instruction this cycle.
- Ins  input  32  current instruction.
- Result  input  32  ALU result, used as the byte address.
- Rdata2  input  32  store data (rt).
- nextPC  input  32  PC+4, used for JAL/JALR writeback.
- Stall  output  1  hold the PC and instruction; the datapath must keep its inputs stable while this is high.
- Wdata  output  32  register writeback value.
- AdrErr  output  1  one-cycle pulse on a misaligned access.
- MemReq  output  1  memory request.
- MemWe  output  1  1 = write.
- MemBe  output  4  byte enables; bit i covers data bits [8i+7:8i].
- MemAdr  output  ADDR_W  word address.
- MemWdata  output  32  write data, replicated into the enabled lanes.
- MemGnt  input  1  memory accepts the request this cycle.
- MemRvalid  input  1  read data valid.
- MemRdata  input  32  read data.

Behaviour:
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B, JAL 0x03. JALR is opcode 0x00 with funct 0x09. Any other opcode is a non-memory op.
- Addressing: MemAdr = Result[ADDR_W+1:2]. Upper bits are ignored, so the address wraps modulo DMEM_SIZE.
- State machine states: IDLE, REQ, WAIT_R, DONE.
- IDLE, memory op with Valid=1 and aligned address:
  - Capture Adr, MemBe, MemWdata, MemWe and the load type into registers.
  - Go to REQ.
  - Stall is driven high combinationally in this same cycle.
- IDLE, misaligned access (LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]!=0):
  - No request is issued.
  - AdrErr=1 for one cycle, Stall=0, Wdata=0; the datapath must suppress the writeback.
- REQ: MemReq=1, with all request fields held stable until MemGnt=1.
  - Store granted: go to DONE.
  - Load granted: go to WAIT_R.
- WAIT_R: wait for MemRvalid=1, then register the aligned load result and go to DONE.
  - MemRvalid in the same cycle as MemGnt is not permitted; the minimum load latency is 1 cycle after grant.
- DONE: Stall=0, Wdata = registered result (stores: Result). The datapath advances at this edge; return to IDLE.
- Latency: a store takes at least 2 stall cycles plus the DONE cycle; a load takes at least 3 stall cycles plus the DONE cycle.
- Byte lanes, little-endian:
  - SB: MemBe = 1<<addr[1:0], data is Rdata2[7:0] replicated ×4.
  - SH: MemBe = 4'b0011<<addr[1:0], data is Rdata2[15:0] replicated ×2.
  - SW: MemBe = 4'b1111.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend the selected lane.
- Non-memory ops (combinational, Stall=0):
  - JAL → Wdata = nextPC.
  - opcode 0x00 with JALR funct → Wdata = nextPC.
  - Otherwise Wdata = Result.
  - Valid=0 → Stall=0, Wdata = Result.
- Reset values: state=IDLE, MemReq=0, MemWe=0, MemBe=0, MemAdr=0, MemWdata=0, AdrErr=0, all result registers 0. Stall and Wdata follow the IDLE combinational rules.
- Reset mid-operation: asynchronous return to IDLE with MemReq deasserted at once. A MemRvalid received in IDLE is ignored.
- MemGnt or MemRvalid outside REQ or WAIT_R respectively is ignored.

Decomposition:
- Shared package/header (common_param.vh): opcode and funct constants (LB…SW, JAL, JALR), DMEM_SIZE, and the state encodings for IDLE/REQ/WAIT_R/DONE.
- Sub-module lsu_align (combinational): given size, signedness and addr[1:0], produces MemBe and the replicated write data, and extracts and extends the load data. Keeps the FSM file focused on the handshake.

Test Plan:
- SW with Result=0x10, Rdata2=0xDEADBEEF, MemGnt delayed 3 cycles → MemReq held for 3 cycles with MemAdr=4, MemBe=4'hF, MemWe=1; Stall high until DONE.
- LB with Result=0x13 and MemRdata=0x80FF1234 after 2 cycles → MemBe=4'b1000; Wdata=0xFFFFFF80 in DONE; LBU on the same access → 0x00000080.
- SH with Result=0x22, Rdata2=0x0000ABCD → MemBe=4'b1100, MemWdata=0xABCDABCD; LHU on the same word returns 0x0000ABCD.
- LW with Result=0x06 → AdrErr pulses once, MemReq never asserted, Stall=0, Wdata=0.
- JAL with nextPC=0x40, then opcode 0x00 with funct 0x09 → Wdata=0x40, Stall=0; ADD with Result=7 → Wdata=7.
- RST low during WAIT_R, then a late MemRvalid → MemReq=0 immediately, state=IDLE, no Wdata update, next load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: opcodes, FSM states, access sizes.
package lsu_pkg;

  localparam int unsigned DMEM_SIZE_DEF = 1024;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_JALR    = 6'h09;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_R,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated data, load lane extract + extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  // Lane enables and replication for stores, extraction and extension for loads.
  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_ldata = '0;
    case (i_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_st_data[7:0]}};
        o_ldata = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_H: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_st_data[15:0]}};
        o_ldata = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        o_be    = '1;
        o_wdata = i_st_data;
        o_ldata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes memory ops, drives a req/gnt/rvalid memory port and
// stalls the datapath until the access completes; also selects the writeback value.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_SIZE = DMEM_SIZE_DEF,
  parameter int unsigned ADDR_W    = $clog2(DMEM_SIZE)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Valid,
  input  logic [31:0]       Ins,
  input  logic [31:0]       Result,
  input  logic [31:0]       Rdata2,
  input  logic [31:0]       nextPC,
  output logic              Stall,
  output logic [31:0]       Wdata,
  output logic              AdrErr,
  output logic              MemReq,
  output logic              MemWe,
  output logic [3:0]        MemBe,
  output logic [ADDR_W-1:0] MemAdr,
  output logic [31:0]       MemWdata,
  input  logic              MemGnt,
  input  logic              MemRvalid,
  input  logic [31:0]       MemRdata
);

  state_t              r_state, w_next;
  logic                r_we;
  logic [3:0]          r_be;
  logic [ADDR_W-1:0]   r_adr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_result;
  size_t               r_size;
  logic                r_signed;
  logic [1:0]          r_off;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_link;
  logic        w_misalign;
  logic        w_start;
  size_t       w_size;
  logic        w_signed;
  size_t       w_al_size;
  logic        w_al_signed;
  logic [1:0]  w_al_off;
  logic [3:0]  w_be;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_data;
  logic        w_unused_bits;

  assign w_opcode      = Ins[31:26];
  assign w_funct       = Ins[5:0];
  assign w_unused_bits = ^{Ins[25:6], Result[31:ADDR_W+2]};

  // Instruction decode: access kind, size, signedness and alignment.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size     = SZ_W;
    w_signed   = 1'b0;
    case (w_opcode)
      OP_LB:  begin w_is_load  = 1'b1; w_size = SZ_B; w_signed = 1'b1; end
      OP_LH:  begin w_is_load  = 1'b1; w_size = SZ_H; w_signed = 1'b1; end
      OP_LW:  begin w_is_load  = 1'b1; w_size = SZ_W; end
      OP_LBU: begin w_is_load  = 1'b1; w_size = SZ_B; end
      OP_LHU: begin w_is_load  = 1'b1; w_size = SZ_H; end
      OP_SB:  begin w_is_store = 1'b1; w_size = SZ_B; end
      OP_SH:  begin w_is_store = 1'b1; w_size = SZ_H; end
      OP_SW:  begin w_is_store = 1'b1; w_size = SZ_W; end
      default: ;
    endcase
    w_misalign = ((w_size == SZ_H) && Result[0]) ||
                 ((w_size == SZ_W) && (Result[1:0] != 2'b00));
    w_is_link  = (w_opcode == OP_JAL) ||
                 ((w_opcode == OP_SPECIAL) && (w_funct == FN_JALR));
    w_start    = Valid && (w_is_load || w_is_store) && !w_misalign;
  end

  // One aligner serves both directions: live decode while idle (store lanes),
  // captured access type afterwards (load extraction).
  assign w_al_size   = (r_state == ST_IDLE) ? w_size       : r_size;
  assign w_al_signed = (r_state == ST_IDLE) ? w_signed     : r_signed;
  assign w_al_off    = (r_state == ST_IDLE) ? Result[1:0]  : r_off;

  lsu_align u_align (
    .i_size    (w_al_size),
    .i_signed  (w_al_signed),
    .i_off     (w_al_off),
    .i_st_data (Rdata2),
    .i_rdata   (MemRdata),
    .o_be      (w_be),
    .o_wdata   (w_st_data),
    .o_ldata   (w_ld_data)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state, stall, address-error and writeback selection.
  always_comb begin
    w_next = r_state;
    Stall  = 1'b0;
    AdrErr = 1'b0;
    Wdata  = Result;
    case (r_state)
      ST_IDLE: begin
        if (Valid && (w_is_load || w_is_store)) begin
          if (w_misalign) begin
            AdrErr = 1'b1;
            Wdata  = '0;
          end else begin
            Stall  = 1'b1;
            w_next = ST_REQ;
          end
        end else if (Valid && w_is_link) begin
          Wdata = nextPC;
        end
      end
      ST_REQ: begin
        Stall = 1'b1;
        if (MemGnt) w_next = r_we ? ST_DONE : ST_WAIT_R;
      end
      ST_WAIT_R: begin
        Stall = 1'b1;
        if (MemRvalid) w_next = ST_DONE;
      end
      default: begin
        Wdata  = r_we ? Result : r_result;
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request fields captured on accept; load data captured on rvalid.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_we     <= 1'b0;
      r_be     <= '0;
      r_adr    <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_size   <= SZ_W;
      r_signed <= 1'b0;
      r_off    <= '0;
    end else begin
      if (r_state == ST_IDLE && w_start) begin
        r_we     <= w_is_store;
        r_be     <= w_be;
        r_adr    <= Result[ADDR_W+1:2];
        r_wdata  <= w_st_data;
        r_size   <= w_size;
        r_signed <= w_signed;
        r_off    <= Result[1:0];
      end
      if (r_state == ST_WAIT_R && MemRvalid) r_result <= w_ld_data;
    end
  end

  assign MemReq   = (r_state == ST_REQ);
  assign MemWe    = r_we;
  assign MemBe    = r_be;
  assign MemAdr   = r_adr;
  assign MemWdata = r_wdata;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: idle-cycle vector table plus hand-written memory transactions.
module tb_lsu;
  import lsu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Valid = 1'b0;
  logic [31:0] Ins = '0;
  logic [31:0] Result = '0;
  logic [31:0] Rdata2 = '0;
  logic [31:0] nextPC = '0;
  logic        Stall;
  logic [31:0] Wdata;
  logic        AdrErr;
  logic        MemReq;
  logic        MemWe;
  logic [3:0]  MemBe;
  logic [9:0]  MemAdr;
  logic [31:0] MemWdata;
  logic        MemGnt = 1'b0;
  logic        MemRvalid = 1'b0;
  logic [31:0] MemRdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  lsu #(.DMEM_SIZE(1024), .ADDR_W(10)) dut (
    .CLK(CLK), .RST(RST), .Valid(Valid), .Ins(Ins), .Result(Result),
    .Rdata2(Rdata2), .nextPC(nextPC), .Stall(Stall), .Wdata(Wdata),
    .AdrErr(AdrErr), .MemReq(MemReq), .MemWe(MemWe), .MemBe(MemBe),
    .MemAdr(MemAdr), .MemWdata(MemWdata), .MemGnt(MemGnt),
    .MemRvalid(MemRvalid), .MemRdata(MemRdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid;
    logic [31:0] ins;
    logic [31:0] result;
    logic [31:0] npc;
    logic        stall;
    logic [31:0] wdata;
    logic        adrerr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h0, fn};
  endfunction

  // Drives one aligned access and checks every cycle until DONE.
  task automatic run_access(input string nm, input logic [5:0] op, input logic [31:0] res,
                            input logic [31:0] rd2, input int gnt_wait, input int rv_wait,
                            input logic [31:0] rdata, input logic [9:0] exp_adr,
                            input logic [3:0] exp_be, input logic [31:0] exp_mwd,
                            input logic exp_we, input logic [31:0] exp_wb);
    @(negedge CLK);
    Valid = 1'b1; Ins = mk(op, 6'h00); Result = res; Rdata2 = rd2;
    MemGnt = 1'b0; MemRvalid = 1'b0; MemRdata = 32'h5555_5555;
    #1;
    chk({nm, " idle stall"},  {31'b0, Stall},  32'd1);
    chk({nm, " idle req"},    {31'b0, MemReq}, 32'd0);
    chk({nm, " idle adrerr"}, {31'b0, AdrErr}, 32'd0);
    for (int c = 0; c < gnt_wait; c++) begin
      @(negedge CLK);
      MemGnt = (c == gnt_wait - 1);
      #1;
      chk({nm, " req"},   {31'b0, MemReq}, 32'd1);
      chk({nm, " stall"}, {31'b0, Stall},  32'd1);
      chk({nm, " adr"},   {22'b0, MemAdr}, {22'b0, exp_adr});
      chk({nm, " be"},    {28'b0, MemBe},  {28'b0, exp_be});
      chk({nm, " we"},    {31'b0, MemWe},  {31'b0, exp_we});
      if (exp_we) chk({nm, " mwdata"}, MemWdata, exp_mwd);
    end
    @(negedge CLK);
    MemGnt = 1'b0;
    if (!exp_we) begin
      for (int c = 0; c < rv_wait; c++) begin
        MemRvalid = (c == rv_wait - 1);
        MemRdata  = (c == rv_wait - 1) ? rdata : 32'h5555_5555;
        #1;
        chk({nm, " wait req"},   {31'b0, MemReq}, 32'd0);
        chk({nm, " wait stall"}, {31'b0, Stall},  32'd1);
        @(negedge CLK);
        MemRvalid = 1'b0;
        MemRdata  = 32'h5555_5555;
      end
    end
    #1;
    chk({nm, " done stall"}, {31'b0, Stall},  32'd0);
    chk({nm, " done req"},   {31'b0, MemReq}, 32'd0);
    chk({nm, " done wdata"}, Wdata, exp_wb);
    @(negedge CLK);
    Valid = 1'b0;
    #1;
    chk({nm, " back idle"}, {31'b0, Stall}, 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, mk(OP_LW, 0),        32'h06, 32'h40, 1'b0, 32'h06, 1'b0};
    vecs[1]  = '{1'b1, mk(OP_LW, 0),        32'h06, 32'h40, 1'b0, 32'h00, 1'b1};
    vecs[2]  = '{1'b1, mk(OP_SW, 0),        32'h11, 32'h40, 1'b0, 32'h00, 1'b1};
    vecs[3]  = '{1'b1, mk(OP_LH, 0),        32'h03, 32'h40, 1'b0, 32'h00, 1'b1};
    vecs[4]  = '{1'b1, mk(OP_LHU, 0),       32'h21, 32'h40, 1'b0, 32'h00, 1'b1};
    vecs[5]  = '{1'b1, mk(OP_SH, 0),        32'h05, 32'h40, 1'b0, 32'h00, 1'b1};
    vecs[6]  = '{1'b1, mk(OP_JAL, 0),       32'h99, 32'h40, 1'b0, 32'h40, 1'b0};
    vecs[7]  = '{1'b1, mk(OP_SPECIAL, 6'h09), 32'h99, 32'h40, 1'b0, 32'h40, 1'b0};
    vecs[8]  = '{1'b1, mk(OP_SPECIAL, 6'h20), 32'h07, 32'h40, 1'b0, 32'h07, 1'b0};
    vecs[9]  = '{1'b1, mk(OP_SPECIAL, 6'h08), 32'h1234, 32'h40, 1'b0, 32'h1234, 1'b0};
    vecs[10] = '{1'b0, mk(OP_JAL, 0),       32'h55, 32'h40, 1'b0, 32'h55, 1'b0};

    // Reset state
    #2;
    chk("rst memreq",   {31'b0, MemReq},   32'd0);
    chk("rst memwe",    {31'b0, MemWe},    32'd0);
    chk("rst membe",    {28'b0, MemBe},    32'd0);
    chk("rst memadr",   {22'b0, MemAdr},   32'd0);
    chk("rst memwdata", MemWdata,          32'd0);
    chk("rst adrerr",   {31'b0, AdrErr},   32'd0);
    chk("rst stall",    {31'b0, Stall},    32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    // Idle-cycle combinational vectors; none of these leave IDLE.
    foreach (vecs[i]) begin
      @(negedge CLK);
      Valid = vecs[i].valid; Ins = vecs[i].ins; Result = vecs[i].result; nextPC = vecs[i].npc;
      #1;
      chk($sformatf("vec%0d stall", i),  {31'b0, Stall},  {31'b0, vecs[i].stall});
      chk($sformatf("vec%0d wdata", i),  Wdata,           vecs[i].wdata);
      chk($sformatf("vec%0d adrerr", i), {31'b0, AdrErr}, {31'b0, vecs[i].adrerr});
      chk($sformatf("vec%0d memreq", i), {31'b0, MemReq}, 32'd0);
    end
    @(negedge CLK);
    Valid = 1'b0;

    //        name    op      Result        Rdata2        gnt rv rdata         adr     be       mwdata        we   wb
    run_access("SW",  OP_SW,  32'h10,       32'hDEADBEEF, 3, 0, 32'h0,         10'd4,  4'b1111, 32'hDEADBEEF, 1'b1, 32'h10);
    run_access("LB",  OP_LB,  32'h13,       32'h0,        1, 2, 32'h80FF1234,  10'd4,  4'b1000, 32'h0,        1'b0, 32'hFFFFFF80);
    run_access("LBU", OP_LBU, 32'h13,       32'h0,        2, 2, 32'h80FF1234,  10'd4,  4'b1000, 32'h0,        1'b0, 32'h00000080);
    run_access("SH",  OP_SH,  32'h22,       32'h0000ABCD, 1, 0, 32'h0,         10'd8,  4'b1100, 32'hABCDABCD, 1'b1, 32'h22);
    run_access("LHU", OP_LHU, 32'h22,       32'h0,        1, 1, 32'hABCD1111,  10'd8,  4'b1100, 32'h0,        1'b0, 32'h0000ABCD);
    run_access("LH",  OP_LH,  32'h22,       32'h0,        1, 3, 32'h80010000,  10'd8,  4'b1100, 32'h0,        1'b0, 32'hFFFF8001);
    run_access("SB",  OP_SB,  32'h01,       32'h123456A5, 1, 0, 32'h0,         10'd0,  4'b0010, 32'hA5A5A5A5, 1'b1, 32'h01);
    run_access("LW",  OP_LW,  32'h00001008, 32'h0,        1, 1, 32'h12345678,  10'd2,  4'b1111, 32'h0,        1'b0, 32'h12345678);

    // Reset while a request is outstanding: MemReq must drop without a clock.
    @(negedge CLK);
    Valid = 1'b1; Ins = mk(OP_LW, 0); Result = 32'h20;
    @(negedge CLK);
    #1;
    chk("rstreq req before", {31'b0, MemReq}, 32'd1);
    Valid = 1'b0; Result = 32'h77;
    RST = 1'b0;
    #1;
    chk("rstreq req after", {31'b0, MemReq}, 32'd0);
    chk("rstreq stall",     {31'b0, Stall},  32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Reset during WAIT_R, then a late rvalid that must be ignored.
    @(negedge CLK);
    Valid = 1'b1; Ins = mk(OP_LW, 0); Result = 32'h20;
    @(negedge CLK);
    MemGnt = 1'b1;
    @(negedge CLK);
    MemGnt = 1'b0;
    #1;
    chk("rstwait stall before", {31'b0, Stall}, 32'd1);
    Valid = 1'b0; Result = 32'h66;
    RST = 1'b0;
    #1;
    chk("rstwait req",   {31'b0, MemReq}, 32'd0);
    chk("rstwait stall", {31'b0, Stall},  32'd0);
    @(negedge CLK);
    RST = 1'b1;
    MemRvalid = 1'b1; MemRdata = 32'hCAFEF00D;
    @(negedge CLK);
    MemRvalid = 1'b0;
    #1;
    chk("late rvalid stall", {31'b0, Stall},  32'd0);
    chk("late rvalid req",   {31'b0, MemReq}, 32'd0);
    chk("late rvalid wdata", Wdata,           32'h66);
    @(negedge CLK);
    #1;
    chk("late rvalid still idle", Wdata, 32'h66);

    // Stray grant in IDLE must not start anything.
    @(negedge CLK);
    MemGnt = 1'b1;
    #1;
    chk("stray gnt req", {31'b0, MemReq}, 32'd0);
    @(negedge CLK);
    MemGnt = 1'b0;
    #1;
    chk("stray gnt stall", {31'b0, Stall}, 32'd0);

    run_access("LW2", OP_LW, 32'h20, 32'h0, 2, 1, 32'h0BADBEEF, 10'd8, 4'b1111, 32'h0, 1'b0, 32'h0BADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
